mips_datapath: RTL and testbench

- Single-cycle MIPS datapath. Holds the PC, the 32x32 register file, the sign-extender, the ALU and the result/operand muxes.
- Driven by an external controller through pcsrc, alucontrol, alusrc, regdst, regwrite and memtoreg. Instruction and data memories sit outside this block.
- Exports the PC, ALU result, store data and the instruction word for the controller.

---
 rtl/mips_pkg.sv | 19 +
 rtl/mips_regfile.sv | 48 ++++
 rtl/mips_datapath.sv | 88 ++++++++
 tb/tb_mips_datapath.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared types and constants for the single-cycle MIPS datapath.
package mips_pkg;

    typedef logic [31:0] word_t;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam word_t RESET_PC_DEFAULT = 32'h0000_0000;

    // Sign-extend a 16-bit immediate to a full word.
    function automatic word_t sign_ext(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

endpackage

// File: rtl/mips_regfile.sv
// 32x32 register file: two combinational read ports, one clocked write port,
// synchronous active-low clear. Register 0 is hardwired to zero.
module mips_regfile
    import mips_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       we,
    input  logic [4:0] ra1,
    input  logic [4:0] ra2,
    input  logic [4:0] wa,
    input  word_t      wd,
    output word_t      rd1,
    output word_t      rd2
);

    word_t rf_q [32];
    word_t rf_d [32];

    // Next-state array: copy current contents, apply the single write, pin $0 to zero.
    always_comb begin
        for (int i = 0; i < 32; i++) begin
            rf_d[i] = rf_q[i];
        end
        if (we && (wa != 5'd0)) begin
            rf_d[wa] = wd;
        end
        rf_d[0] = '0;
    end

    // Register storage; reset takes priority over any pending write.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 32; i++) begin
                rf_q[i] <= rf_d[i];
            end
        end
    end

    // Reads see only committed state, so a same-cycle write is not bypassed.
    assign rd1 = (ra1 == 5'd0) ? '0 : rf_q[ra1];
    assign rd2 = (ra2 == 5'd0) ? '0 : rf_q[ra2];

endmodule

// File: rtl/mips_datapath.sv
// Single-cycle MIPS datapath: PC, register file, sign-extender, ALU and
// operand/result muxes. Control comes from an external decoder.
module mips_datapath
    import mips_pkg::*;
#(
    parameter word_t RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pcsrc,
    input  logic [2:0]  alucontrol,
    input  logic        alusrc,
    input  logic        regdst,
    output logic        o_zero,
    input  logic        regwrite,
    input  logic        memtoreg,
    input  logic [31:0] instr,
    input  logic [31:0] readdata,
    output logic [31:0] o_pc,
    output logic [31:0] o_aluresult,
    output logic [31:0] o_writedata,
    output logic [31:0] o_instr_contr
);

    word_t      pc_q;
    word_t      pc_d;
    word_t      pcplus4;
    word_t      pcbranch;
    word_t      signimm;
    word_t      rd1;
    word_t      rd2;
    word_t      srcb;
    word_t      aluresult;
    word_t      result;
    logic [4:0] writereg;

    assign signimm = sign_ext(instr[15:0]);

    // Next PC: sequential or branch target, both wrapping mod 2^32.
    always_comb begin
        pcplus4  = pc_q + 32'd4;
        pcbranch = pcplus4 + {signimm[29:0], 2'b00};
        pc_d     = pcsrc ? pcbranch : pcplus4;
    end

    // Program counter register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    mips_regfile u_regfile (
        .clk   (clk),
        .reset (reset),
        .we    (regwrite),
        .ra1   (instr[25:21]),
        .ra2   (instr[20:16]),
        .wa    (writereg),
        .wd    (result),
        .rd1   (rd1),
        .rd2   (rd2)
    );

    // Operand B select, ALU, write-register and writeback muxes.
    always_comb begin
        srcb = alusrc ? signimm : rd2;
        unique case (alucontrol)
            ALU_AND: aluresult = rd1 & srcb;
            ALU_OR:  aluresult = rd1 | srcb;
            ALU_ADD: aluresult = rd1 + srcb;
            ALU_SUB: aluresult = rd1 - srcb;
            ALU_SLT: aluresult = ($signed(rd1) < $signed(srcb)) ? 32'd1 : 32'd0;
            default: aluresult = '0;
        endcase
        writereg = regdst ? instr[15:11] : instr[20:16];
        result   = memtoreg ? readdata : aluresult;
    end

    assign o_pc          = pc_q;
    assign o_aluresult   = aluresult;
    assign o_zero        = (aluresult == '0);
    assign o_writedata   = rd2;
    assign o_instr_contr = instr;

endmodule

// File: tb/tb_mips_datapath.sv
// Self-checking bench for mips_datapath: each scenario pushes expected values
// into a scoreboard queue as it drives stimulus, then pops and compares.
module tb_mips_datapath;

    logic        clk;
    logic        reset;
    logic        pcsrc;
    logic [2:0]  alucontrol;
    logic        alusrc;
    logic        regdst;
    logic        o_zero;
    logic        regwrite;
    logic        memtoreg;
    logic [31:0] instr;
    logic [31:0] readdata;
    logic [31:0] o_pc;
    logic [31:0] o_aluresult;
    logic [31:0] o_writedata;
    logic [31:0] o_instr_contr;

    logic [31:0] exp_q [$];
    logic [31:0] e;
    logic [31:0] pc_m;
    int          n_cmp;
    int          n_bad;

    mips_datapath dut (
        .clk           (clk),
        .reset         (reset),
        .pcsrc         (pcsrc),
        .alucontrol    (alucontrol),
        .alusrc        (alusrc),
        .regdst        (regdst),
        .o_zero        (o_zero),
        .regwrite      (regwrite),
        .memtoreg      (memtoreg),
        .instr         (instr),
        .readdata      (readdata),
        .o_pc          (o_pc),
        .o_aluresult   (o_aluresult),
        .o_writedata   (o_writedata),
        .o_instr_contr (o_instr_contr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ctrl(input logic ps, input logic [2:0] ac, input logic as,
                            input logic rdst, input logic rw, input logic m2r);
        pcsrc      = ps;
        alucontrol = ac;
        alusrc     = as;
        regdst     = rdst;
        regwrite   = rw;
        memtoreg   = m2r;
        #1;
    endtask

    task automatic test_reset();
        reset    = 1'b0;
        instr    = 32'h0;
        readdata = 32'h0;
        set_ctrl(1'b0, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        reset = 1'b1;
        #1;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h1);
        e = exp_q.pop_front(); n_cmp++;
        if (o_pc !== e) begin n_bad++; $display("FAIL reset_pc: got %h expected %h", o_pc, e); end
        e = exp_q.pop_front(); n_cmp++;
        if (o_writedata !== e) begin n_bad++; $display("FAIL reset_wd: got %h expected %h", o_writedata, e); end
        e = exp_q.pop_front(); n_cmp++;
        if (o_aluresult !== e) begin n_bad++; $display("FAIL reset_alu: got %h expected %h", o_aluresult, e); end
        e = exp_q.pop_front(); n_cmp++;
        if ({31'b0, o_zero} !== e) begin n_bad++; $display("FAIL reset_zero: got %b expected %h", o_zero, e); end
        pc_m = 32'h0;
    endtask

    task automatic test_addi();
        instr = 32'h2008_0005;
        set_ctrl(1'b0, 3'b010, 1'b1, 1'b0, 1'b1, 1'b0);
        exp_q.push_back(32'd5);
        exp_q.push_back(32'd0);
        exp_q.push_back(32'h2008_0005);
        e = exp_q.pop_front(); n_cmp++;
        if (o_aluresult !== e) begin n_bad++; $display("FAIL addi_alu: got %h expected %h", o_aluresult, e); end
        e = exp_q.pop_front(); n_cmp++;
        if ({31'b0, o_zero} !== e) begin n_bad++; $display("FAIL addi_zero: got %b expected %h", o_zero, e); end
        e = exp_q.pop_front(); n_cmp++;
        if (o_instr_contr !== e) begin n_bad++; $display("FAIL instr_pass: got %h expected %h", o_instr_contr, e); end
        tick();
        pc_m = pc_m + 32'd4;
        exp_q.push_back(pc_m);
        e = exp_q.pop_front(); n_cmp++;
        if (o_pc !== e) begin n_bad++; $display("FAIL addi_pc: got %h expected %h", o_pc, e); end
        instr = 32'hAC08_0000;
        set_ctrl(1'b0, 3'b010, 1'b1, 1'b0, 1'b0, 1'b0);
        exp_q.push_back(32'd5);
        e = exp_q.pop_front(); n_cmp++;
        if (o_writedata !== e) begin n_bad++; $display("FAIL addi_sw_rt: got %h expected %h", o_writedata, e); end
    endtask

    task automatic test_sub();
        instr = 32'h0108_4022;
        set_ctrl(1'b0, 3'b110, 1'b0, 1'b1, 1'b1, 1'b0);
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd1);
        exp_q.push_back(32'd5);
        e = exp_q.pop_front(); n_cmp++;
        if (o_aluresult !== e) begin n_bad++; $display("FAIL sub_alu: got %h expected %h", o_aluresult, e); end
        e = exp_q.pop_front(); n_cmp++;
        if ({31'b0, o_zero} !== e) begin n_bad++; $display("FAIL sub_zero: got %b expected %h", o_zero, e); end
        e = exp_q.pop_front(); n_cmp++;
        if (o_writedata !== e) begin n_bad++; $display("FAIL no_bypass: got %h expected %h", o_writedata, e); end
        tick();
        pc_m = pc_m + 32'd4;
        instr = 32'hAC08_0000;
        set_ctrl(1'b0, 3'b010, 1'b1, 1'b0, 1'b0, 1'b0);
        exp_q.push_back(32'd0);
        e = exp_q.pop_front(); n_cmp++;
        if (o_writedata !== e) begin n_bad++; $display("FAIL sub_r8: got %h expected %h", o_writedata, e); end
    endtask

    task automatic test_lw();
        instr    = 32'h8C09_0004;
        readdata = 32'hDEAD_BEEF;
        set_ctrl(1'b0, 3'b010, 1'b1, 1'b0, 1'b1, 1'b1);
        exp_q.push_back(32'd4);
        e = exp_q.pop_front(); n_cmp++;
        if (o_aluresult !== e) begin n_bad++; $display("FAIL lw_addr: got %h expected %h", o_aluresult, e); end
        tick();
        pc_m = pc_m + 32'd4;
        instr = 32'hAC09_0000;
        set_ctrl(1'b0, 3'b010, 1'b1, 1'b0, 1'b0, 1'b0);
        exp_q.push_back(32'hDEAD_BEEF);
        e = exp_q.pop_front(); n_cmp++;
        if (o_writedata !== e) begin n_bad++; $display("FAIL lw_r9: got %h expected %h", o_writedata, e); end
        instr = 32'h2000_0007;
        set_ctrl(1'b0, 3'b010, 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        pc_m = pc_m + 32'd4;
        instr = 32'hAC00_0000;
        set_ctrl(1'b0, 3'b010, 1'b1, 1'b0, 1'b0, 1'b0);
        exp_q.push_back(32'd0);
        exp_q.push_back(pc_m);
        e = exp_q.pop_front(); n_cmp++;
        if (o_writedata !== e) begin n_bad++; $display("FAIL r0_write: got %h expected %h", o_writedata, e); end
        e = exp_q.pop_front(); n_cmp++;
        if (o_pc !== e) begin n_bad++; $display("FAIL seq_pc: got %h expected %h", o_pc, e); end
    endtask

    task automatic test_branch();
        logic [31:0] imm_w;
        reset = 1'b0;
        set_ctrl(1'b0, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        exp_q.push_back(32'h10);
        e = exp_q.pop_front(); n_cmp++;
        if (o_pc !== e) begin n_bad++; $display("FAIL br_start: got %h expected %h", o_pc, e); end
        instr = 32'h1000_FFFF;
        set_ctrl(1'b1, 3'b110, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        exp_q.push_back(32'h10);
        e = exp_q.pop_front(); n_cmp++;
        if (o_pc !== e) begin n_bad++; $display("FAIL br_back: got %h expected %h", o_pc, e); end
        instr = 32'h1000_0003;
        tick();
        exp_q.push_back(32'h20);
        e = exp_q.pop_front(); n_cmp++;
        if (o_pc !== e) begin n_bad++; $display("FAIL br_fwd: got %h expected %h", o_pc, e); end
        instr = 32'h1000_FFFB;
        tick();
        exp_q.push_back(32'h10);
        e = exp_q.pop_front(); n_cmp++;
        if (o_pc !== e) begin n_bad++; $display("FAIL br_back5: got %h expected %h", o_pc, e); end
        set_ctrl(1'b0, 3'b110, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        exp_q.push_back(32'h14);
        e = exp_q.pop_front(); n_cmp++;
        if (o_pc !== e) begin n_bad++; $display("FAIL br_not_taken: got %h expected %h", o_pc, e); end
        // Large negative offset wraps below zero.
        instr = 32'h1000_8000;
        imm_w = 32'hFFFF_8000;
        pc_m  = 32'h14 + 32'd4 + (imm_w << 2);
        set_ctrl(1'b1, 3'b110, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        exp_q.push_back(pc_m);
        e = exp_q.pop_front(); n_cmp++;
        if (o_pc !== e) begin n_bad++; $display("FAIL br_wrap: got %h expected %h", o_pc, e); end
        pcsrc = 1'b0;
    endtask

    task automatic test_alu_slt();
        instr = 32'h2008_FFFF;
        set_ctrl(1'b0, 3'b010, 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        instr = 32'h2009_0001;
        tick();
        // Unused controls at X with regwrite low must leave state alone.
        instr      = 32'h0109_502A;
        regwrite   = 1'b0;
        alucontrol = 3'bxxx;
        alusrc     = 1'bx;
        regdst     = 1'bx;
        memtoreg   = 1'bx;
        readdata   = 32'hxxxx_xxxx;
        tick();
        instr = 32'h0109_502A;
        set_ctrl(1'b0, 3'b111, 1'b0, 1'b1, 1'b0, 1'b0);
        exp_q.push_back(32'd1);
        exp_q.push_back(32'd1);
        e = exp_q.pop_front(); n_cmp++;
        if (o_writedata !== e) begin n_bad++; $display("FAIL x_guard_r9: got %h expected %h", o_writedata, e); end
        e = exp_q.pop_front(); n_cmp++;
        if (o_aluresult !== e) begin n_bad++; $display("FAIL slt_neg_lt_pos: got %h expected %h", o_aluresult, e); end
        instr = 32'h0128_502A;
        #1;
        exp_q.push_back(32'd0);
        exp_q.push_back(32'hFFFF_FFFF);
        e = exp_q.pop_front(); n_cmp++;
        if (o_aluresult !== e) begin n_bad++; $display("FAIL slt_pos_lt_neg: got %h expected %h", o_aluresult, e); end
        e = exp_q.pop_front(); n_cmp++;
        if (o_writedata !== e) begin n_bad++; $display("FAIL x_guard_r8: got %h expected %h", o_writedata, e); end
        alucontrol = 3'b110;
        #1;
        exp_q.push_back(32'd2);
        e = exp_q.pop_front(); n_cmp++;
        if (o_aluresult !== e) begin n_bad++; $display("FAIL sub_pos_neg: got %h expected %h", o_aluresult, e); end
        instr = 32'h0109_502A;
        alucontrol = 3'b000;
        #1;
        exp_q.push_back(32'd1);
        e = exp_q.pop_front(); n_cmp++;
        if (o_aluresult !== e) begin n_bad++; $display("FAIL and_op: got %h expected %h", o_aluresult, e); end
        alucontrol = 3'b001;
        #1;
        exp_q.push_back(32'hFFFF_FFFF);
        e = exp_q.pop_front(); n_cmp++;
        if (o_aluresult !== e) begin n_bad++; $display("FAIL or_op: got %h expected %h", o_aluresult, e); end
        alucontrol = 3'b010;
        #1;
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd1);
        e = exp_q.pop_front(); n_cmp++;
        if (o_aluresult !== e) begin n_bad++; $display("FAIL add_wrap: got %h expected %h", o_aluresult, e); end
        e = exp_q.pop_front(); n_cmp++;
        if ({31'b0, o_zero} !== e) begin n_bad++; $display("FAIL add_wrap_zero: got %b expected %h", o_zero, e); end
        alucontrol = 3'b011;
        #1;
        exp_q.push_back(32'd0);
        e = exp_q.pop_front(); n_cmp++;
        if (o_aluresult !== e) begin n_bad++; $display("FAIL undef_op: got %h expected %h", o_aluresult, e); end
    endtask

    task automatic test_mid_reset();
        instr    = 32'h2008_0033;
        readdata = 32'h0;
        set_ctrl(1'b0, 3'b010, 1'b1, 1'b0, 1'b1, 1'b0);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        instr = 32'hAC08_0000;
        set_ctrl(1'b0, 3'b010, 1'b1, 1'b0, 1'b0, 1'b0);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        e = exp_q.pop_front(); n_cmp++;
        if (o_pc !== e) begin n_bad++; $display("FAIL midrst_pc: got %h expected %h", o_pc, e); end
        e = exp_q.pop_front(); n_cmp++;
        if (o_writedata !== e) begin n_bad++; $display("FAIL midrst_r8: got %h expected %h", o_writedata, e); end
        instr = 32'hAC09_0000;
        #1;
        exp_q.push_back(32'h0);
        e = exp_q.pop_front(); n_cmp++;
        if (o_writedata !== e) begin n_bad++; $display("FAIL midrst_r9: got %h expected %h", o_writedata, e); end
    endtask

    initial begin
        n_cmp      = 0;
        n_bad      = 0;
        reset      = 1'b0;
        pcsrc      = 1'b0;
        alucontrol = 3'b010;
        alusrc     = 1'b0;
        regdst     = 1'b0;
        regwrite   = 1'b0;
        memtoreg   = 1'b0;
        instr      = 32'h0;
        readdata   = 32'h0;
        test_reset();
        test_addi();
        test_sub();
        test_lw();
        test_branch();
        test_alu_slt();
        test_mid_reset();
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
